counter_read_arbiter: RTL and testbench

- Shares the 32-bit read port of a 64-bit atomic event counter among NUM_REQ requesters.
- The counter port returns 32 bits per request: low word with atomic=1 (upper word snapshotted), upper snapshot with atomic=0.
- This block sequences each 64-bit read as an uninterruptible low-then-high pair and arbitrates round-robin between requesters.
- It returns one coherent 64-bit value per transaction.

---
 rtl/counter_read_arbiter_if.sv | 46 ++++
 rtl/counter_read_arbiter.sv | 161 ++++++++++++++++
 tb/tb_counter_read_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/counter_read_arbiter_if.sv
// Bundle of the requester-side read handshake and the counter read-port
// handshake shared by the arbiter and its environment.
//
// Handshake semantics:
//   rd_req_i[i] is a level request held by requester i until it sees its
//   single-cycle rd_valid_o[i] pulse; rd_data_o/rd_err_o are qualified by
//   that pulse. ctr_req_o is a single-cycle beat (ctr_atomic_o=1 for the low
//   word, 0 for the upper snapshot); the counter answers each beat with one
//   ctr_ack_i cycle carrying ctr_count_i. There is no back-pressure on the
//   completion side: a valid pulse is consumed in the cycle it appears.
interface counter_read_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0] rd_req_i;
    logic [NUM_REQ-1:0] rd_valid_o;
    logic               rd_err_o;
    logic [63:0]        rd_data_o;
    logic               ctr_req_o;
    logic               ctr_atomic_o;
    logic               ctr_ack_i;
    logic [31:0]        ctr_count_i;

    // Arbiter view.
    modport slave (
        input  rd_req_i,
        input  ctr_ack_i,
        input  ctr_count_i,
        output rd_valid_o,
        output rd_err_o,
        output rd_data_o,
        output ctr_req_o,
        output ctr_atomic_o
    );

    // Environment view (requesters plus counter).
    modport master (
        output rd_req_i,
        output ctr_ack_i,
        output ctr_count_i,
        input  rd_valid_o,
        input  rd_err_o,
        input  rd_data_o,
        input  ctr_req_o,
        input  ctr_atomic_o
    );
endinterface

// File: rtl/counter_read_arbiter.sv
// Round-robin arbiter that shares the 32-bit read port of a 64-bit event
// counter. Each transaction is an uninterruptible low (atomic) beat followed
// by the upper-snapshot beat, so every requester gets one coherent value.
module counter_read_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ACK_TIMEOUT = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    counter_read_arbiter_if.slave   bus,
    output logic                    busy_o,
    output logic                    err_o,
    output logic [2:0]              dbg_state_o
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SW = PW + 1;
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ISSUE_LO = 3'd1,
        WAIT_LO  = 3'd2,
        ISSUE_HI = 3'd3,
        WAIT_HI  = 3'd4,
        RESP     = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] last_q, last_d;
    logic [PW-1:0] grant_q, grant_d;
    logic [31:0]   lo_q, lo_d;
    logic [31:0]   hi_q, hi_d;
    logic          txn_err_q, txn_err_d;
    logic          err_q, err_d;
    logic [TW-1:0] wait_q, wait_d;

    logic          pick_found;
    logic [PW-1:0] pick_idx;
    logic [SW-1:0] rr_cand;

    // Round-robin search: first set request upward from last granted + 1.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        rr_cand    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rr_cand = SW'(last_q) + SW'(1) + SW'(i);
            if (rr_cand >= SW'(NUM_REQ)) begin
                rr_cand = rr_cand - SW'(NUM_REQ);
            end
            if (!pick_found && bus.rd_req_i[rr_cand[PW-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = rr_cand[PW-1:0];
            end
        end
    end

    // Next-state logic: beat sequencing, ack timeout and sticky error.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        grant_d   = grant_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        txn_err_d = txn_err_q;
        err_d     = err_q;
        wait_d    = '0;

        // An ack outside a wait state has no beat to answer.
        if (bus.ctr_ack_i && (state_q != WAIT_LO) && (state_q != WAIT_HI)) begin
            err_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d   = pick_idx;
                    lo_d      = '0;
                    hi_d      = '0;
                    txn_err_d = 1'b0;
                    state_d   = ISSUE_LO;
                end
            end
            ISSUE_LO: state_d = WAIT_LO;
            WAIT_LO: begin
                if (bus.ctr_ack_i) begin
                    lo_d    = bus.ctr_count_i;
                    state_d = ISSUE_HI;
                end else if (wait_q == TW'(ACK_TIMEOUT - 1)) begin
                    err_d     = 1'b1;
                    txn_err_d = 1'b1;
                    state_d   = RESP;
                end else begin
                    wait_d = wait_q + TW'(1);
                end
            end
            ISSUE_HI: state_d = WAIT_HI;
            WAIT_HI: begin
                if (bus.ctr_ack_i) begin
                    hi_d    = bus.ctr_count_i;
                    state_d = RESP;
                end else if (wait_q == TW'(ACK_TIMEOUT - 1)) begin
                    err_d     = 1'b1;
                    txn_err_d = 1'b1;
                    state_d   = RESP;
                end else begin
                    wait_d = wait_q + TW'(1);
                end
            end
            RESP: begin
                last_d  = grant_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; the pointer resets so requester 0 wins first.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            last_q    <= PW'(NUM_REQ - 1);
            grant_q   <= '0;
            lo_q      <= '0;
            hi_q      <= '0;
            txn_err_q <= 1'b0;
            err_q     <= 1'b0;
            wait_q    <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            grant_q   <= grant_d;
            lo_q      <= lo_d;
            hi_q      <= hi_d;
            txn_err_q <= txn_err_d;
            err_q     <= err_d;
            wait_q    <= wait_d;
        end
    end

    // Outputs decoded from state; data and error are forced to 0 outside RESP.
    always_comb begin
        bus.ctr_req_o    = (state_q == ISSUE_LO) || (state_q == ISSUE_HI);
        bus.ctr_atomic_o = (state_q == ISSUE_LO);
        bus.rd_valid_o   = '0;
        bus.rd_data_o    = '0;
        bus.rd_err_o     = 1'b0;
        if (state_q == RESP) begin
            bus.rd_valid_o = NUM_REQ'(1) << grant_q;
            bus.rd_err_o   = txn_err_q;
            if (!txn_err_q) begin
                bus.rd_data_o = {hi_q, lo_q};
            end
        end
        busy_o      = (state_q != IDLE);
        err_o       = err_q;
        dbg_state_o = state_q;
    end

endmodule

// File: tb/tb_counter_read_arbiter.sv
// Directed bench for counter_read_arbiter: a vector table for single reads
// plus hand-written sequences for arbitration, timeout, reset and stray acks.
module tb_counter_read_arbiter;

    localparam int NR = 4;

    logic       clk;
    logic       reset_n;
    logic       busy_o;
    logic       err_o;
    logic [2:0] dbg_state_o;

    counter_read_arbiter_if #(.NUM_REQ(NR)) bus ();

    counter_read_arbiter #(.NUM_REQ(NR), .ACK_TIMEOUT(4)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus),
        .busy_o      (busy_o),
        .err_o       (err_o),
        .dbg_state_o (dbg_state_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- counter model ----------------
    // Answers each beat one cycle later. The atomic beat returns the live low
    // word, snapshots the live upper word and then bumps the live counter.
    logic [63:0] live;
    logic [31:0] snap;
    logic        pend;
    logic [31:0] pend_data;
    logic [63:0] live_init;
    int          load_seq;
    int          seen_seq;
    logic        ack_en;
    logic        force_ack;

    initial begin
        bus.ctr_ack_i   = 1'b0;
        bus.ctr_count_i = '0;
        live      = '0;
        snap      = '0;
        pend      = 1'b0;
        pend_data = '0;
        seen_seq  = 0;
        forever begin
            @(negedge clk);
            if (load_seq != seen_seq) begin
                live     = live_init;
                seen_seq = load_seq;
            end
            if (!reset_n) begin
                bus.ctr_ack_i   = 1'b0;
                bus.ctr_count_i = '0;
                pend            = 1'b0;
            end else begin
                bus.ctr_ack_i   = pend | force_ack;
                bus.ctr_count_i = pend ? pend_data : 32'h0;
                pend            = 1'b0;
                if (bus.ctr_req_o && ack_en) begin
                    pend = 1'b1;
                    if (bus.ctr_atomic_o) begin
                        pend_data = live[31:0];
                        snap      = live[63:32];
                        live      = live + 64'd1;
                    end else begin
                        pend_data = snap;
                    end
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    int          checks;
    int          errors;
    logic [63:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        reset_n        = 1'b0;
        bus.rd_req_i   = '0;
        force_ack      = 1'b0;
        ack_en         = 1'b1;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic load_counter(input logic [63:0] val);
        live_init = val;
        load_seq  = load_seq + 1;
    endtask

    // Advances cycle by cycle until a valid pulse or the budget runs out.
    task automatic wait_valid(input int budget, output int k, output logic [NR-1:0] v,
                              output logic [63:0] d, output logic e);
        k = 0;
        v = '0;
        d = '0;
        e = 1'b0;
        while (k < budget && v == '0) begin
            @(posedge clk);
            @(negedge clk);
            k++;
            if (bus.rd_valid_o != '0) begin
                v = bus.rd_valid_o;
                d = bus.rd_data_o;
                e = bus.rd_err_o;
            end
        end
    endtask

    typedef struct {
        logic [NR-1:0] req;
        logic [63:0]   live;
        logic [NR-1:0] exp_valid;
        logic [63:0]   exp_data;
    } vec_t;

    vec_t          vecs[4];
    int            k;
    int            cyc;
    int            last_cyc;
    logic [NR-1:0] v;
    logic [63:0]   d;
    logic          e;
    logic [1:0]    beats[$];
    int            vcyc[$];
    logic          saw_valid;
    logic [1:0]    exp_beats[4];

    initial begin
        checks       = 0;
        errors       = 0;
        load_seq     = 0;
        live_init    = '0;
        ack_en       = 1'b1;
        force_ack    = 1'b0;
        bus.rd_req_i = '0;
        reset_n      = 1'b0;

        vecs[0] = '{req: 4'b0010, live: 64'h0000_0001_FFFF_FFFF,
                    exp_valid: 4'b0010, exp_data: 64'h0000_0001_FFFF_FFFF};
        vecs[1] = '{req: 4'b0001, live: 64'h0000_0005_0000_0010,
                    exp_valid: 4'b0001, exp_data: 64'h0000_0005_0000_0010};
        vecs[2] = '{req: 4'b1000, live: 64'hDEAD_BEEF_0123_4567,
                    exp_valid: 4'b1000, exp_data: 64'hDEAD_BEEF_0123_4567};
        vecs[3] = '{req: 4'b0100, live: 64'hFFFF_FFFF_FFFF_FFFF,
                    exp_valid: 4'b0100, exp_data: 64'hFFFF_FFFF_FFFF_FFFF};

        // ---- reset state ----
        repeat (2) @(negedge clk);
        chk("rst_valid", 64'(bus.rd_valid_o), 64'h0);
        chk("rst_ctr_req", 64'(bus.ctr_req_o), 64'h0);
        chk("rst_data", bus.rd_data_o, 64'h0);
        chk("rst_busy", 64'(busy_o), 64'h0);
        chk("rst_err", 64'(err_o), 64'h0);
        do_reset();

        // ---- table: single reads, carry coherence, wrap of the full count ----
        for (int i = 0; i < 4; i++) begin
            load_counter(vecs[i].live);
            @(negedge clk);
            bus.rd_req_i = vecs[i].req;
            wait_valid(12, k, v, d, e);
            chk($sformatf("vec%0d_latency", i), 64'(k), 64'd5);
            chk($sformatf("vec%0d_valid", i), 64'(v), 64'(vecs[i].exp_valid));
            chk($sformatf("vec%0d_data", i), d, vecs[i].exp_data);
            chk($sformatf("vec%0d_rd_err", i), 64'(e), 64'h0);
            bus.rd_req_i = '0;
            @(negedge clk);
            chk($sformatf("vec%0d_idle_after", i), 64'(busy_o), 64'h0);
        end

        // ---- simultaneous 0 and 2 after reset: no interleaved beats ----
        do_reset();
        load_counter(64'h0000_0007_0000_0001);
        @(negedge clk);
        exp_q.delete();
        exp_q.push_back(64'h1);
        exp_q.push_back(64'h4);
        beats.delete();
        vcyc.delete();
        bus.rd_req_i = 4'b0101;
        cyc = 0;
        repeat (12) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (bus.ctr_req_o) beats.push_back({bus.ctr_req_o, bus.ctr_atomic_o});
            if (bus.rd_valid_o != '0) begin
                vcyc.push_back(cyc);
                if (exp_q.size() > 0) chk("pair_valid", 64'(bus.rd_valid_o), exp_q.pop_front());
                else chk("pair_extra_valid", 64'(bus.rd_valid_o), 64'h0);
                chk("pair_data", bus.rd_data_o,
                    (vcyc.size() == 1) ? 64'h0000_0007_0000_0001 : 64'h0000_0007_0000_0002);
                bus.rd_req_i = bus.rd_req_i & ~bus.rd_valid_o;
            end
        end
        bus.rd_req_i = '0;
        exp_beats[0] = 2'b11;
        exp_beats[1] = 2'b10;
        exp_beats[2] = 2'b11;
        exp_beats[3] = 2'b10;
        chk("pair_beat_count", 64'(beats.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < beats.size()) chk($sformatf("pair_beat%0d", i), 64'(beats[i]), 64'(exp_beats[i]));
            else chk($sformatf("pair_beat%0d_missing", i), 64'(i), 64'(beats.size() + 4));
        end
        chk("pair_valid_count", 64'(vcyc.size()), 64'd2);
        if (vcyc.size() >= 2) begin
            chk("pair_first_cycle", 64'(vcyc[0]), 64'd5);
            chk("pair_spacing", 64'(vcyc[1] - vcyc[0]), 64'd6);
        end
        chk("pair_pending_left", 64'(exp_q.size()), 64'd0);

        // ---- fairness with all four held ----
        do_reset();
        exp_q.delete();
        exp_q.push_back(64'h1);
        exp_q.push_back(64'h2);
        exp_q.push_back(64'h4);
        exp_q.push_back(64'h8);
        exp_q.push_back(64'h1);
        exp_q.push_back(64'h2);
        bus.rd_req_i = 4'b1111;
        cyc = 0;
        last_cyc = -1;
        repeat (36) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (bus.rd_valid_o != '0) begin
                if (exp_q.size() > 0) chk($sformatf("rr_grant_c%0d", cyc), 64'(bus.rd_valid_o), exp_q.pop_front());
                else chk("rr_extra_valid", 64'(bus.rd_valid_o), 64'h0);
                if (last_cyc >= 0) chk($sformatf("rr_spacing_c%0d", cyc), 64'(cyc - last_cyc), 64'd6);
                last_cyc = cyc;
            end
        end
        bus.rd_req_i = '0;
        chk("rr_all_served", 64'(exp_q.size()), 64'd0);

        // ---- timeout on the low beat, then a normal read ----
        do_reset();
        chk("to_err_before", 64'(err_o), 64'h0);
        ack_en = 1'b0;
        bus.rd_req_i = 4'b0001;
        wait_valid(12, k, v, d, e);
        chk("to_latency", 64'(k), 64'd6);
        chk("to_valid", 64'(v), 64'h1);
        chk("to_rd_err", 64'(e), 64'h1);
        chk("to_data_zero", d, 64'h0);
        chk("to_err_sticky", 64'(err_o), 64'h1);
        bus.rd_req_i = '0;
        ack_en = 1'b1;
        load_counter(64'h0000_0002_0000_0003);
        @(negedge clk);
        bus.rd_req_i = 4'b0010;
        wait_valid(12, k, v, d, e);
        chk("to_next_valid", 64'(v), 64'h2);
        chk("to_next_data", d, 64'h0000_0002_0000_0003);
        chk("to_next_rd_err", 64'(e), 64'h0);
        chk("to_next_err_kept", 64'(err_o), 64'h1);
        bus.rd_req_i = '0;

        // ---- reset while in WAIT_HI ----
        do_reset();
        bus.rd_req_i = 4'b0010;
        k = 0;
        while (k < 10 && dbg_state_o != 3'd4) begin
            @(posedge clk);
            @(negedge clk);
            k++;
        end
        chk("rh_reach_wait_hi", 64'(k), 64'd4);
        reset_n = 1'b0;
        #1;
        chk("rh_state", 64'(dbg_state_o), 64'h0);
        chk("rh_busy", 64'(busy_o), 64'h0);
        chk("rh_ctr_req", 64'(bus.ctr_req_o), 64'h0);
        chk("rh_data", bus.rd_data_o, 64'h0);
        bus.rd_req_i = '0;
        saw_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (bus.rd_valid_o != '0) saw_valid = 1'b1;
        end
        chk("rh_no_valid", 64'(saw_valid), 64'h0);
        reset_n = 1'b1;
        @(negedge clk);
        load_counter(64'h0000_00AA_0000_00BB);
        bus.rd_req_i = 4'b1000;
        wait_valid(12, k, v, d, e);
        chk("rh_req3_latency", 64'(k), 64'd5);
        chk("rh_req3_valid", 64'(v), 64'h8);
        chk("rh_req3_data", d, 64'h0000_00AA_0000_00BB);
        bus.rd_req_i = '0;
        @(negedge clk);
        bus.rd_req_i = 4'b1001;
        wait_valid(12, k, v, d, e);
        chk("rh_both_first", 64'(v), 64'h1);
        bus.rd_req_i = 4'b1000;
        wait_valid(12, k, v, d, e);
        chk("rh_both_second", 64'(v), 64'h8);
        chk("rh_both_second_lat", 64'(k), 64'd6);
        bus.rd_req_i = '0;

        // ---- stray ack while idle ----
        do_reset();
        chk("sp_err_before", 64'(err_o), 64'h0);
        force_ack = 1'b1;
        repeat (2) @(negedge clk);
        force_ack = 1'b0;
        saw_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.rd_valid_o != '0) saw_valid = 1'b1;
        end
        chk("sp_err_set", 64'(err_o), 64'h1);
        chk("sp_no_valid", 64'(saw_valid), 64'h0);
        chk("sp_state_idle", 64'(dbg_state_o), 64'h0);
        chk("sp_not_busy", 64'(busy_o), 64'h0);

        // ---- report ----
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
